mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage).
- Grants one access at a time and holds the address, write data and write enable stable until the memory answers.
- Drives per-port stall signals; the pipeline gates the pc and pipeline-register clocks with these stalls.
- Sits between the pipelined datapath and the external memory model.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 16, maximum cycles to wait for mem_ready before aborting (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
if_req  input  1  instruction fetch request, level-held
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched instruction
if_stall  output  1  fetch not complete this cycle
d_req  input  1  data access request, level-held
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_rdata  output  DW  load data
d_stall  output  1  data access not complete this cycle
mem_req  output  1  access in progress
mem_we  output  1  write enable of the current access
mem_addr  output  AW  latched address
mem_wdata  output  DW  latched write data
mem_rdata  input  DW  read data, valid when mem_ready=1
mem_ready  input  1  one-cycle completion strobe
err  output  1  sticky timeout flag

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- State machine has three states: IDLE, BUSY_I, BUSY_D. Reset puts it in IDLE.
- Reset values:
  - mem_req, mem_we, err = 0.
  - mem_addr, mem_wdata = 0.
  - if_rdata, d_rdata holding registers = 0.
  - timeout counter = 0.
- IDLE:
  - d_req=1 → latch d_addr, d_wdata, d_we; go to BUSY_D.
  - else if_req=1 → latch if_addr, set mem_we=0; go to BUSY_I.
  - Data has fixed priority unless ARB_RR_EN is defined.
- BUSY_x:
  - mem_req=1 combinationally from state. mem_addr, mem_we and mem_wdata stay constant.
  - Counter increments each cycle.
  - mem_ready=1 → go to IDLE and clear the counter.
  - Read data: mem_rdata is passed combinationally to the owning port's rdata in the same cycle, and captured into that port's holding register. Outside completion cycles, rdata shows the holding register.
- Stall rules, both combinational:
  - if_stall = if_req & ~(state==BUSY_I & mem_ready).
  - d_stall = d_req & ~(state==BUSY_D & mem_ready).
- Latency:
  - Request seen in IDLE at edge k. mem_req is high from cycle k+1.
  - Fastest completion is mem_ready in cycle k+1, so minimum 2 cycles per access.
  - After completion there is one mandatory IDLE cycle before the next grant.
- Dropping the request while BUSY (pipeline flush): the access still runs to mem_ready, because it cannot be aborted. Read data still updates the holding register. Stores still commit.
- mem_ready while IDLE is ignored.
- Timeout:
  - Counter reaching TIMEOUT-1 in BUSY without mem_ready → go to IDLE, set err=1 (sticky until reset).
  - The requester stays stalled and is re-arbitrated.
- Reset mid-access: go to IDLE immediately and deassert mem_req. Stalls follow the req inputs (req=1 ⇒ stall=1).
- The counter is sized to $clog2(TIMEOUT)+1 bits and saturates.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - A last_grant flip-flop (reset value = I) records which port was granted last.
  - When both requests are pending in IDLE, the port not granted last wins. A single pending request is always granted.
- Undefined: fixed data priority. Instruction fetch can starve under continuous d_req.

Test Plan:
- Single fetch: reset then release; if_req=1, if_addr=0x40; mem_ready in the 3rd BUSY cycle with mem_rdata=0x20080005 → mem_addr=0x40, mem_we=0, if_stall high 3 cycles then low, if_rdata=0x20080005 in the completion cycle.
- Conflict: if_req and d_req asserted together; d_we=1, d_addr=0x54, d_wdata=0x7 → data granted first (mem_we=1, mem_addr=0x54, mem_wdata=0x7). Fetch is granted after one IDLE cycle. With ARB_RR_EN, a second simultaneous conflict grants fetch.
- Load with mem_ready on the first BUSY cycle, mem_rdata=0xDEADBEEF → d_stall low in cycle k+1, d_rdata=0xDEADBEEF, and it is held afterwards.
- Flush: drop if_req in the middle of BUSY_I → mem_req stays high until mem_ready, if_stall=0, next state is IDLE.
- Timeout: TIMEOUT=4, mem_ready never asserted → state returns to IDLE after 4 BUSY cycles, err=1, re-grant follows; err stays 1 until reset.
- Async reset asserted in the middle of BUSY_D, between clock edges → mem_req=0 and err=0 immediately. After release, a pending d_req is re-issued from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (IF) and data (MEM) ports.
// Define ARB_RR_EN to alternate grants on conflict instead of fixed data priority.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam int unsigned     CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_hold_q, if_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;

  logic pick_d, pick_i;
  logic done_i, done_d;

`ifdef ARB_RR_EN
  // 0 = fetch granted last, 1 = data granted last
  logic last_grant_q, last_grant_d;

  assign pick_d = d_req & (~if_req | ~last_grant_q);
`else
  assign pick_d = d_req;
`endif
  assign pick_i = if_req & ~pick_d;

  assign done_i = (state_q == BUSY_I) & mem_ready;
  assign done_d = (state_q == BUSY_D) & mem_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_hold_d = if_hold_q;
    d_hold_d  = d_hold_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
`ifdef ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (pick_i) begin
          state_d = BUSY_I;
          addr_d  = if_addr;
          we_d    = 1'b0;
`ifdef ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == BUSY_I) if_hold_d = mem_rdata;
          else                   d_hold_d  = mem_rdata;
        end else if (cnt_q >= CNT_LAST) begin
          // Abandon the access; the requester stays stalled and is re-arbitrated.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

  assign if_rdata  = done_i ? mem_rdata : if_hold_q;
  assign d_rdata   = done_d ? mem_rdata : d_hold_q;
  assign if_stall  = if_req & ~done_i;
  assign d_stall   = d_req & ~done_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and completions are checked by a monitor.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  int unsigned lat;
  int unsigned busy_cnt;
  logic [31:0] rd_val;
  logic        force_ready;
  logic        resp_ready;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
  } grant_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } comp_t;

  grant_t gq[$];
  comp_t  cq[$];

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign mem_rdata = rd_val;
  assign mem_ready = force_ready | resp_ready;

  // Memory model: strobes ready in the lat-th busy cycle (lat=0 never answers)
  initial begin
    resp_ready = 1'b0;
    busy_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) busy_cnt++;
      else         busy_cnt = 0;
      resp_ready = mem_req && (lat != 0) && (busy_cnt == lat);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_g(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chkw);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.chk_wdata = chkw;
    gq.push_back(g);
  endtask

  task automatic push_c(input bit is_d, input logic [31:0] rdata);
    comp_t c;
    c.is_d = is_d; c.rdata = rdata;
    cq.push_back(c);
  endtask

  // Monitor: pops an expected grant on each new access and an expected response on completion
  grant_t cur;
  bit     have_cur  = 1'b0;
  logic   prev_mreq = 1'b0;
  always @(negedge clk) begin
    comp_t c;
    if (mem_req && !prev_mreq) begin
      if (gq.size() == 0) begin
        chk("grant_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        have_cur = 1'b0;
      end else begin
        cur      = gq.pop_front();
        have_cur = 1'b1;
      end
    end
    if (mem_req && have_cur) begin
      chk("grant_we", 32'(mem_we), 32'(cur.we));
      chk("grant_addr", mem_addr, cur.addr);
      if (cur.chk_wdata) chk("grant_wdata", mem_wdata, cur.wdata);
    end
    if (mem_req && mem_ready) begin
      if (cq.size() == 0) begin
        chk("completion_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        c = cq.pop_front();
        if (c.is_d) begin
          chk("d_rdata_completion", d_rdata, c.rdata);
          chk("d_stall_completion", 32'(d_stall), 32'd0);
          chk("if_stall_other", 32'(if_stall), 32'(if_req));
        end else begin
          chk("if_rdata_completion", if_rdata, c.rdata);
          chk("if_stall_completion", 32'(if_stall), 32'd0);
          chk("d_stall_other", 32'(d_stall), 32'(d_req));
        end
      end
    end
    prev_mreq = mem_req;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall(input bit is_d, output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (is_d ? d_stall : if_stall) n++;
      else break;
    end
  endtask

  // Waits for the selected ports to complete, dropping each request after its completion
  task automatic run_until_done(input bit want_i, input bit want_d);
    bit di, dd;
    di = !want_i;
    dd = !want_d;
    for (int n = 0; n < 60 && !(di && dd); n++) begin
      @(negedge clk);
      if (!di && if_req && !if_stall) di = 1'b1;
      if (!dd && d_req && !d_stall) dd = 1'b1;
      @(posedge clk);
      #1;
      if (di && want_i) if_req = 1'b0;
      if (dd && want_d) d_req = 1'b0;
    end
    chk("done_in_budget", 32'(di && dd), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; force_ready = 1'b0; lat = 3; rd_val = '0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stalls", 32'({if_stall, d_stall}), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Single fetch, ready in the third busy cycle
    lat = 3; rd_val = 32'h2008_0005; if_addr = 32'h40; if_req = 1'b1;
    push_g(1'b0, 32'h40, 32'h0, 1'b0);
    push_c(1'b0, 32'h2008_0005);
    count_stall(1'b0, n);
    chk("fetch_stall_cycles", 32'(n), 32'd3);
    cyc();
    if_req = 1'b0;
    cyc();
    chk("fetch_rdata_held", if_rdata, 32'h2008_0005);
    chk("fetch_back_idle", 32'(mem_req), 32'd0);

    // Conflict: store vs fetch, then load vs fetch
    lat = 1; rd_val = 32'h1111_2222;
    if_addr = 32'h80; if_req = 1'b1;
    d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7; d_req = 1'b1;
    push_g(1'b1, 32'h54, 32'h7, 1'b1);
    push_c(1'b1, 32'h1111_2222);
`ifdef ARB_RR_EN
    push_g(1'b0, 32'h80, 32'h0, 1'b0);
    push_c(1'b0, 32'h1111_2222);
    push_g(1'b0, 32'h60, 32'h99, 1'b1);
    push_c(1'b1, 32'h1111_2222);
`else
    push_g(1'b0, 32'h60, 32'h99, 1'b1);
    push_c(1'b1, 32'h1111_2222);
    push_g(1'b0, 32'h80, 32'h0, 1'b0);
    push_c(1'b0, 32'h1111_2222);
`endif
    count_stall(1'b1, n);
    chk("store_stall_cycles", 32'(n), 32'd1);
    cyc();
    d_we = 1'b0; d_addr = 32'h60; d_wdata = 32'h99;
    run_until_done(1'b1, 1'b1);
    cyc();

    // Load answered on the first busy cycle
    lat = 1; rd_val = 32'hDEAD_BEEF;
    d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0; d_req = 1'b1;
    push_g(1'b0, 32'h100, 32'h0, 1'b1);
    push_c(1'b1, 32'hDEAD_BEEF);
    count_stall(1'b1, n);
    chk("load_stall_cycles", 32'(n), 32'd1);
    chk("load_rdata_passthru", d_rdata, 32'hDEAD_BEEF);
    cyc();
    d_req = 1'b0;
    cyc();
    chk("load_rdata_held", d_rdata, 32'hDEAD_BEEF);

    // Stray ready while idle must be ignored
    rd_val = 32'h0BAD_F00D; force_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("idle_ready_no_req", 32'(mem_req), 32'd0);
    chk("idle_ready_d_hold", d_rdata, 32'hDEAD_BEEF);
    chk("idle_ready_if_hold", if_rdata, 32'h1111_2222);
    cyc();
    force_ready = 1'b0;
    cyc();

    // Flush: fetch dropped mid-access still runs to completion
    lat = 3; rd_val = 32'hCAFE_0001; if_addr = 32'h200; if_req = 1'b1;
    push_g(1'b0, 32'h200, 32'h0, 1'b0);
    push_c(1'b0, 32'hCAFE_0001);
    cyc();
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("flush_mem_req_held", 32'(mem_req), 32'd1);
    chk("flush_if_stall", 32'(if_stall), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("flush_back_idle", 32'(mem_req), 32'd0);
    chk("flush_rdata_held", if_rdata, 32'hCAFE_0001);
    cyc();

    // Timeout with TIMEOUT=4, then a successful retry
    chk("err_before_timeout", 32'(err), 32'd0);
    lat = 0; rd_val = 32'h1234_5678;
    d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55; d_req = 1'b1;
    push_g(1'b1, 32'h300, 32'h55, 1'b1);
    push_g(1'b1, 32'h300, 32'h55, 1'b1);
    push_c(1'b1, 32'h1234_5678);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) n++;
      else if (n > 0) break;
    end
    chk("timeout_busy_cycles", 32'(n), 32'd4);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_d_stall", 32'(d_stall), 32'd1);
    lat = 2;
    run_until_done(1'b0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);
    cyc();

    // Asynchronous reset between edges during a data access
    lat = 0; d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0; d_req = 1'b1;
    push_g(1'b0, 32'h400, 32'h0, 1'b1);
    cyc();
    cyc();
    @(negedge clk);
    chk("pre_reset_busy", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_d_stall", 32'(d_stall), 32'd1);
    chk("async_rst_d_rdata", d_rdata, 32'd0);
    lat = 2; rd_val = 32'h55AA_55AA;
    push_g(1'b0, 32'h400, 32'h0, 1'b1);
    push_c(1'b1, 32'h55AA_55AA);
    cyc();
    reset = 1'b0;
    run_until_done(1'b0, 1'b1);
    chk("err_after_reset", 32'(err), 32'd0);
    cyc();
    cyc();

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("completion_queue_empty", 32'(cq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
